// File: rtl/knn_dist_engine.sv
// knn_dist_engine: sweeps the training pair memory for one query and streams two
// distances per cycle, with their class labels, into the k-NN top-5 selector.
// Optional build macro: KNN_MANHATTAN_EN selects the L1 distance instead of the
// default squared Euclidean distance. Latency is the same in both builds.
module knn_dist_engine #(
  parameter int NUM_FEAT  = 4,
  parameter int FEAT_W    = 8,
  parameter int DIST_W    = 19,
  parameter int NUM_TRAIN = 256,
  parameter int PAIR_AW   = 7
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [NUM_FEAT*FEAT_W-1:0] query,
  output logic                       mem_rd_en,
  output logic [PAIR_AW-1:0]         mem_addr,
  input  logic [NUM_FEAT*FEAT_W-1:0] mem_data_a,
  input  logic [NUM_FEAT*FEAT_W-1:0] mem_data_b,
  input  logic                       mem_class_a,
  input  logic                       mem_class_b,
  output logic                       sel_clear,
  output logic                       out_valid,
  output logic [DIST_W-1:0]          dist_a,
  output logic [DIST_W-1:0]          dist_b,
  output logic                       class_a,
  output logic                       class_b,
  output logic                       busy,
  output logic                       done
);

  localparam int VEC_W = NUM_FEAT * FEAT_W;
  localparam int SQ_W  = 2 * FEAT_W;
  localparam logic [PAIR_AW-1:0] LAST_ADDR = PAIR_AW'(NUM_TRAIN / 2 - 1);

  // Pairs are fetched two samples at a time, so the training set must split evenly.
  if ((NUM_TRAIN % 2) != 0 || NUM_TRAIN < 2) begin : g_bad_num_train
    $error("knn_dist_engine: NUM_TRAIN must be even and >= 2");
  end
  if (PAIR_AW != $clog2(NUM_TRAIN / 2)) begin : g_bad_pair_aw
    $error("knn_dist_engine: PAIR_AW must equal clog2(NUM_TRAIN/2)");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               rd_en_q, rd_en_d;
  logic [PAIR_AW-1:0] addr_q, addr_d;
  logic               sel_clear_q, sel_clear_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [VEC_W-1:0]   query_q, query_d;

  logic vld_p0, vld_p1, vld_p2, out_valid_q;
  logic [1:0] cls_p1, cls_p2, class_q;
  logic [1:0][NUM_FEAT-1:0][FEAT_W-1:0] diff_p1;
  logic [1:0][NUM_FEAT-1:0][SQ_W-1:0]   sq_p2;
  logic [1:0][DIST_W-1:0]               dist_q;
  logic [1:0][VEC_W-1:0]                mem_vec;
  logic [1:0]                           mem_cls;

  assign mem_vec = {mem_data_b, mem_data_a};
  assign mem_cls = {mem_class_b, mem_class_a};

  function automatic logic [FEAT_W-1:0] abs_diff(input logic [FEAT_W-1:0] q,
                                                 input logic [FEAT_W-1:0] x);
    return (q >= x) ? (q - x) : (x - q);
  endfunction

  // Squares never overflow SQ_W, so no saturation is needed anywhere.
  function automatic logic [SQ_W-1:0] feat_term(input logic [FEAT_W-1:0] d);
`ifdef KNN_MANHATTAN_EN
    return SQ_W'(d);
`else
    return SQ_W'(d) * SQ_W'(d);
`endif
  endfunction

  function automatic logic [DIST_W-1:0] tree_sum(input logic [NUM_FEAT-1:0][SQ_W-1:0] t);
    logic [DIST_W-1:0] acc;
    acc = '0;
    for (int f = 0; f < NUM_FEAT; f++) acc = acc + DIST_W'(t[f]);
    return acc;
  endfunction

  // Sweep control: next state and next values of the registered control outputs.
  always_comb begin
    state_d     = state_q;
    rd_en_d     = rd_en_q;
    addr_d      = addr_q;
    sel_clear_d = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    query_d     = query_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_RUN;
          query_d     = query;
          sel_clear_d = 1'b1;
          busy_d      = 1'b1;
          rd_en_d     = 1'b1;
          addr_d      = '0;
        end
      end
      S_RUN: begin
        if (addr_q == LAST_ADDR) begin
          rd_en_d = 1'b0;
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_q + PAIR_AW'(1);
        end
      end
      S_DRAIN: begin
        if (!(vld_p0 || vld_p1 || vld_p2)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers; reset aborts a sweep at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      sel_clear_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      query_q     <= '0;
    end else begin
      state_q     <= state_d;
      rd_en_q     <= rd_en_d;
      addr_q      <= addr_d;
      sel_clear_q <= sel_clear_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      query_q     <= query_d;
    end
  end

  // Valid bits: p0 marks memory data present, then one bit per pipeline stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0      <= 1'b0;
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      vld_p0      <= rd_en_q;
      vld_p1      <= vld_p0;
      vld_p2      <= vld_p1;
      out_valid_q <= vld_p2;
    end
  end

  // S1 / S2 datapath: per-feature absolute difference, then square (or pass-through).
  always_ff @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      for (int f = 0; f < NUM_FEAT; f++) begin
        diff_p1[l][f] <= abs_diff(query_q[f*FEAT_W +: FEAT_W], mem_vec[l][f*FEAT_W +: FEAT_W]);
        sq_p2[l][f]   <= feat_term(diff_p1[l][f]);
      end
    end
    cls_p1 <= mem_cls;
    cls_p2 <= cls_p1;
  end

  // S3 output registers: sum per lane, held while no valid pair arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      dist_q  <= '0;
      class_q <= '0;
    end else if (vld_p2) begin
      for (int l = 0; l < 2; l++) dist_q[l] <= tree_sum(sq_p2[l]);
      class_q <= cls_p2;
    end
  end

  assign mem_rd_en = rd_en_q;
  assign mem_addr  = addr_q;
  assign sel_clear = sel_clear_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign dist_a    = dist_q[0];
  assign dist_b    = dist_q[1];
  assign class_a   = class_q[0];
  assign class_b   = class_q[1];

endmodule

// File: tb/tb_knn_dist_engine.sv
// tb_knn_dist_engine: scoreboard bench for knn_dist_engine with a one-cycle-latency
// pair memory model. Build with +define+KNN_MANHATTAN_EN to check the L1 variant.
module tb_knn_dist_engine;

  localparam int NF = 4;
  localparam int FW = 8;
  localparam int DW = 19;
  localparam int NT = 256;
  localparam int AW = 7;
  localparam int NP = NT / 2;
  localparam int VW = NF * FW;

`ifdef KNN_MANHATTAN_EN
  localparam int EXP_T2_B = 10;
  localparam int EXP_T3   = 1020;
`else
  localparam int EXP_T2_B = 30;
  localparam int EXP_T3   = 260100;
`endif

  typedef struct packed {
    logic [DW-1:0] da;
    logic [DW-1:0] db;
    logic          ca;
    logic          cb;
  } sb_t;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [VW-1:0] query;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [VW-1:0] mem_data_a, mem_data_b;
  logic          mem_class_a, mem_class_b;
  logic          sel_clear, out_valid, class_a, class_b, busy, done;
  logic [DW-1:0] dist_a, dist_b;

  logic [VW-1:0] mem_a [NP];
  logic [VW-1:0] mem_b [NP];
  logic          cls_a [NP];
  logic          cls_b [NP];

  sb_t           sb[$];
  int            sb_cyc[$];
  logic [VW-1:0] exp_query;

  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  int rd_cnt = 0, v_cnt = 0, clr_cnt = 0, done_cnt = 0;
  int exp_addr = 0, sel_cyc = 0, first_valid_cyc = 0, last_valid_cyc = 0;
  bit first_pending = 1'b0;
  logic [DW-1:0] first_da, first_db, last_da;
  logic          first_ca;

  knn_dist_engine #(
    .NUM_FEAT(NF), .FEAT_W(FW), .DIST_W(DW), .NUM_TRAIN(NT), .PAIR_AW(AW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .query(query),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_data_a(mem_data_a), .mem_data_b(mem_data_b),
    .mem_class_a(mem_class_a), .mem_class_b(mem_class_b),
    .sel_clear(sel_clear), .out_valid(out_valid),
    .dist_a(dist_a), .dist_b(dist_b), .class_a(class_a), .class_b(class_b),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Training pair memory: one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_data_a  <= mem_a[mem_addr];
      mem_data_b  <= mem_b[mem_addr];
      mem_class_a <= cls_a[mem_addr];
      mem_class_b <= cls_b[mem_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int ref_dist(input logic [VW-1:0] q, input logic [VW-1:0] x);
    int s, d;
    s = 0;
    for (int f = 0; f < NF; f++) begin
      d = int'(q[f*FW +: FW]) - int'(x[f*FW +: FW]);
`ifdef KNN_MANHATTAN_EN
      s += (d < 0) ? -d : d;
`else
      s += d * d;
`endif
    end
    return s;
  endfunction

  // Monitor: pushes expectations as reads issue, pops and compares as results emerge.
  always @(negedge clk) begin
    sb_t e;
    if (sel_clear) begin
      clr_cnt++;
      exp_addr = 0;
      sel_cyc = cyc;
      first_pending = 1'b1;
      check_eq("clr_vs_valid", out_valid, 0);
    end
    if (mem_rd_en) begin
      rd_cnt++;
      check_eq("mem_addr", mem_addr, exp_addr);
      exp_addr++;
      e.da = DW'(ref_dist(exp_query, mem_a[mem_addr]));
      e.db = DW'(ref_dist(exp_query, mem_b[mem_addr]));
      e.ca = cls_a[mem_addr];
      e.cb = cls_b[mem_addr];
      sb.push_back(e);
      sb_cyc.push_back(cyc);
    end
    if (out_valid) begin
      v_cnt++;
      check_eq("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("dist_a", dist_a, e.da);
        check_eq("dist_b", dist_b, e.db);
        check_eq("class_a", class_a, e.ca);
        check_eq("class_b", class_b, e.cb);
        check_eq("latency", cyc - sb_cyc.pop_front(), 4);
      end
      if (first_pending) begin
        first_pending = 1'b0;
        first_valid_cyc = cyc;
        first_da = dist_a;
        first_db = dist_b;
        first_ca = class_a;
        check_eq("clr_lead", (cyc - sel_cyc) >= 4, 1);
      end
      last_valid_cyc = cyc;
      last_da = dist_a;
    end
    if (done) begin
      done_cnt++;
      check_eq("busy_at_done", busy, 0);
      check_eq("done_after_last", cyc - last_valid_cyc, 1);
    end
    if (reset) begin
      sb.delete();
      sb_cyc.delete();
      first_pending = 1'b0;
    end
  end

  task automatic fill_random();
    for (int i = 0; i < NP; i++) begin
      mem_a[i] = $urandom;
      mem_b[i] = $urandom;
      cls_a[i] = 1'($urandom);
      cls_b[i] = 1'($urandom);
    end
  endtask

  task automatic run_sweep(input logic [VW-1:0] q, input bit poke);
    int v0, c0, d0, t;
    v0 = v_cnt; c0 = clr_cnt; d0 = done_cnt;
    exp_query = q;
    query = q;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("busy_after_start", busy, 1);
    check_eq("sel_clear_pulse", sel_clear, 1);
    query = $urandom;
    t = 0;
    while (done_cnt == d0 && t < 600) begin
      @(posedge clk); #1;
      t++;
      if (poke) begin
        start = (t == 60);
        if (t == 60) query = $urandom;
      end
    end
    start = 1'b0;
    check_eq("done_timeout", t < 600, 1);
    check_eq("valid_count", v_cnt - v0, NP);
    check_eq("valid_span", last_valid_cyc - first_valid_cyc + 1, NP);
    check_eq("sel_clear_count", clr_cnt - c0, 1);
    check_eq("done_count", done_cnt - d0, 1);
    check_eq("sb_drained", sb.size(), 0);
    check_eq("busy_idle", busy, 0);
    check_eq("dist_hold", dist_a, last_da);
  endtask

  initial begin
    int v0, d0, t;
    reset = 1'b1;
    start = 1'b0;
    query = '0;
    exp_query = '0;
    fill_random();

    // 1: reset, then idle
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_eq("idle_outs", {mem_rd_en, sel_clear, out_valid, busy, done, class_a, class_b}, 0);
    check_eq("idle_addr", mem_addr, 0);
    check_eq("idle_dist_a", dist_a, 0);
    check_eq("idle_dist_b", dist_b, 0);
    check_eq("idle_no_rd", rd_cnt, 0);

    // 2: directed pair 0
    mem_a[0] = 32'h04030201; cls_a[0] = 1'b1;
    mem_b[0] = 32'h00000000; cls_b[0] = 1'b0;
    run_sweep(32'h04030201, 1'b0);
    check_eq("t2_dist_a", first_da, 0);
    check_eq("t2_dist_b", first_db, EXP_T2_B);
    check_eq("t2_class_a", first_ca, 1);

    // 3: maximal distance
    mem_a[0] = 32'hFFFFFFFF;
    mem_b[0] = 32'hFFFFFFFF;
    run_sweep(32'h00000000, 1'b0);
    check_eq("t3_dist_a", first_da, EXP_T3);
    check_eq("t3_dist_b", first_db, EXP_T3);

    // 4: full random sweep with an ignored start mid-sweep
    fill_random();
    run_sweep($urandom, 1'b1);

    // 5: reset at pair 50
    exp_query = $urandom;
    query = exp_query;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t = 0;
    while (!(mem_rd_en && mem_addr == 50) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check_eq("t5_reach_50", t < 200, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    v0 = v_cnt; d0 = done_cnt;
    check_eq("t5_out_valid", out_valid, 0);
    check_eq("t5_busy", busy, 0);
    check_eq("t5_rd_en", mem_rd_en, 0);
    repeat (10) @(posedge clk);
    #1;
    check_eq("t5_no_valid", v_cnt - v0, 0);
    check_eq("t5_no_done", done_cnt - d0, 0);
    run_sweep($urandom, 1'b0);

    // 6: back-to-back queries
    fill_random();
    run_sweep($urandom, 1'b0);
    run_sweep($urandom, 1'b0);
    run_sweep($urandom, 1'b1);

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
